softmax_norm: RTL

SOFTMAX_NORM -- requirements
Module: softmax_norm

---
 rtl/attention_pkg.sv | 15 +
 rtl/seq_divider.sv | 89 ++++++++
 rtl/softmax_norm.sv | 137 +++++++++++++
 3 files changed

// File: rtl/attention_pkg.sv
// Shared attention-pipeline definitions: row geometry, fixed-point widths
// and the normalizer state encoding.
package attention_pkg;

  localparam int ROW_LEN = 4;
  localparam int EX_W    = 9;
  localparam int PROB_W  = 8;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DIVIDE  = 2'd1,
    EMIT    = 2'd2
  } attn_state_e;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider producing one quotient bit per cycle, MSB first, with
// zero-divisor forcing and saturation of a full-scale quotient.
module seq_divider #(
  parameter int EX_W   = 9,
  parameter int PROB_W = 8,
  parameter int SUM_W  = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [EX_W+PROB_W-1:0] dividend,
  input  logic [SUM_W-1:0]       divisor,
  output logic                   busy,
  output logic                   done,
  output logic [PROB_W-1:0]      quotient
);

  localparam int QW    = PROB_W + 1;
  localparam int CNT_W = $clog2(QW + 1);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0] rem_q, rem_d;
  logic [SUM_W-1:0] dvs_q, dvs_d;
  logic [QW-1:0]    shf_q, shf_d;
  logic [QW-1:0]    quo_q, quo_d;
  logic [SUM_W:0]   trial_s;
  logic             ge_s;
  logic [QW-1:0]    q_full_s;

  // Only the low QW dividend bits need shifting in: the numerator is at most
  // 2^PROB_W times the divisor, so the upper bits preload the remainder.
  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    shf_d    = shf_q;
    quo_d    = quo_q;
    trial_s  = {rem_q, shf_q[QW-1]};
    ge_s     = (trial_s >= {1'b0, dvs_q});
    q_full_s = {quo_q[QW-2:0], ge_s};
    done     = busy_q && (cnt_q == CNT_W'(PROB_W));
    if (dvs_q == {SUM_W{1'b0}}) begin
      quotient = {PROB_W{1'b0}};
    end else if (q_full_s[QW-1]) begin
      quotient = {PROB_W{1'b1}};
    end else begin
      quotient = q_full_s[PROB_W-1:0];
    end
    if (busy_q) begin
      rem_d = ge_s ? SUM_W'(trial_s - {1'b0, dvs_q}) : trial_s[SUM_W-1:0];
      shf_d = {shf_q[QW-2:0], 1'b0};
      quo_d = q_full_s;
      cnt_d = cnt_q + CNT_W'(1);
      busy_d = !done;
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = {CNT_W{1'b0}};
      rem_d  = SUM_W'(dividend >> QW);
      dvs_d  = divisor;
      shf_d  = dividend[QW-1:0];
      quo_d  = {QW{1'b0}};
    end else begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= {CNT_W{1'b0}};
      rem_q  <= {SUM_W{1'b0}};
      dvs_q  <= {SUM_W{1'b0}};
      shf_q  <= {QW{1'b0}};
      quo_q  <= {QW{1'b0}};
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      shf_q  <= shf_d;
      quo_q  <= quo_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/softmax_norm.sv
// Softmax normalizer: collects a row of e^x values, then emits each value
// divided by the row sum as a UQ0.8 probability, in input order.
module softmax_norm #(
  parameter int ROW_LEN = attention_pkg::ROW_LEN,
  parameter int EX_W    = attention_pkg::EX_W,
  parameter int PROB_W  = attention_pkg::PROB_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [EX_W-1:0]   ex_in,
  input  logic              ex_vld,
  output logic              ex_rdy,
  output logic [PROB_W-1:0] prob_out,
  output logic              prob_vld,
  input  logic              prob_rdy,
  output logic              row_last
);

  import attention_pkg::*;

  localparam int IDX_W = $clog2(ROW_LEN);
  localparam int SUM_W = EX_W + IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_LEN - 1);

  attn_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [EX_W-1:0]   buf_q [ROW_LEN];
  logic [EX_W-1:0]   buf_d [ROW_LEN];
  logic [PROB_W-1:0] prob_q, prob_d;
  logic              prob_vld_q, prob_vld_d;
  logic              row_last_q, row_last_d;
  logic              ex_rdy_q, ex_rdy_d;
  logic              div_start_s, div_busy_s, div_done_s;
  logic [PROB_W-1:0] div_quot_s;

  seq_divider #(
    .EX_W   (EX_W),
    .PROB_W (PROB_W),
    .SUM_W  (SUM_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start_s),
    .dividend ({buf_q[idx_q], {PROB_W{1'b0}}}),
    .divisor  (sum_q),
    .busy     (div_busy_s),
    .done     (div_done_s),
    .quotient (div_quot_s)
  );

  // Next-state and datapath updates; ex_rdy is registered from the next state.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    buf_d       = buf_q;
    prob_d      = prob_q;
    prob_vld_d  = prob_vld_q;
    row_last_d  = row_last_q;
    div_start_s = 1'b0;
    case (state_q)
      COLLECT: begin
        if (ex_vld) begin
          buf_d[idx_q] = ex_in;
          sum_d        = sum_q + SUM_W'(ex_in);
          if (idx_q == LAST_IDX) begin
            idx_d   = {IDX_W{1'b0}};
            state_d = DIVIDE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = COLLECT;
        end
      end
      DIVIDE: begin
        if (div_done_s) begin
          prob_d     = div_quot_s;
          prob_vld_d = 1'b1;
          row_last_d = (idx_q == LAST_IDX);
          state_d    = EMIT;
        end else begin
          div_start_s = !div_busy_s;
        end
      end
      EMIT: begin
        if (prob_rdy) begin
          prob_vld_d = 1'b0;
          row_last_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            idx_d   = {IDX_W{1'b0}};
            sum_d   = {SUM_W{1'b0}};
            state_d = COLLECT;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = DIVIDE;
          end
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
    ex_rdy_d = (state_d == COLLECT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= COLLECT;
      idx_q      <= {IDX_W{1'b0}};
      sum_q      <= {SUM_W{1'b0}};
      buf_q      <= '{default: '0};
      prob_q     <= {PROB_W{1'b0}};
      prob_vld_q <= 1'b0;
      row_last_q <= 1'b0;
      ex_rdy_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      buf_q      <= buf_d;
      prob_q     <= prob_d;
      prob_vld_q <= prob_vld_d;
      row_last_q <= row_last_d;
      ex_rdy_q   <= ex_rdy_d;
    end
  end

  assign ex_rdy   = ex_rdy_q;
  assign prob_out = prob_q;
  assign prob_vld = prob_vld_q;
  assign row_last = row_last_q;

endmodule
